// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Stall/forward controller for a 5-stage MIPS pipeline. A shift-register scoreboard
//   holds valid/a1/a2/a3/Tnew for every stage after D (entry 0 = E, 1 = M, 2 = W, ...),
//   and a cycle-counted timer tracks the busy multiply/divide unit. Stall and all forward
//   selects are combinational from that registered state and the D-stage decode fields.
//
// Ports
//   i_clk, i_rst_n          clock (rising edge), asynchronous active-low reset
//   i_d_valid               D holds a real instruction
//   i_d_a1/i_d_a2           D-stage rs/rt read addresses
//   i_d_a3                  D-stage destination (0 = no write)
//   i_d_tuse_rs/rt          cycles until D needs rs/rt
//   i_d_tnew                Tnew of the D instruction as it enters E
//   i_d_md_use              D instruction is any MDU op
//   i_d_md_start/i_d_md_div D launches a multi-cycle op (div = 1 selects divide latency)
//   i_flush                 kills the instruction entering E
//   o_stall                 freeze PC and D, bubble into E
//   o_d_sel_rs/rt           D-stage forward selects
//   o_e_sel_a/b             E-stage ALU operand selects
//   o_m_sel_rt              M-stage store-data select
//   o_md_busy               MDU timer non-zero
//   Select encoding: 0 = own pipeline register, k+1 = forward from tracked stage k.

module hazard_scoreboard #(
    parameter int unsigned DEPTH   = 3,
    parameter int unsigned TNEW_W  = 2,
    parameter int unsigned MUL_LAT = 5,
    parameter int unsigned DIV_LAT = 10,
    parameter int unsigned SEL_W   = $clog2(DEPTH + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_d_valid,
    input  logic [4:0]        i_d_a1,
    input  logic [4:0]        i_d_a2,
    input  logic [4:0]        i_d_a3,
    input  logic [TNEW_W-1:0] i_d_tuse_rs,
    input  logic [TNEW_W-1:0] i_d_tuse_rt,
    input  logic [TNEW_W-1:0] i_d_tnew,
    input  logic              i_d_md_use,
    input  logic              i_d_md_start,
    input  logic              i_d_md_div,
    input  logic              i_flush,
    output logic              o_stall,
    output logic [SEL_W-1:0]  o_d_sel_rs,
    output logic [SEL_W-1:0]  o_d_sel_rt,
    output logic [SEL_W-1:0]  o_e_sel_a,
    output logic [SEL_W-1:0]  o_e_sel_b,
    output logic [SEL_W-1:0]  o_m_sel_rt,
    output logic              o_md_busy
);

    localparam int unsigned MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

    // Scoreboard entries, index 0 is the youngest (E stage)
    logic              r_valid [DEPTH];
    logic [4:0]        r_a1    [DEPTH];
    logic [4:0]        r_a2    [DEPTH];
    logic [4:0]        r_a3    [DEPTH];
    logic [TNEW_W-1:0] r_tnew  [DEPTH];
    logic [CNT_W-1:0]  r_md_cnt;

    logic              w_writer [DEPTH];
    logic              w_rs_hit;
    logic              w_rt_hit;
    logic [TNEW_W-1:0] w_rs_tnew;
    logic [TNEW_W-1:0] w_rt_tnew;
    logic              w_stall_rs;
    logic              w_stall_rt;
    logic              w_stall_md;
    logic              w_issue;

    always_comb begin
        for (int k = 0; k < int'(DEPTH); k++) begin
            w_writer[k] = r_valid[k] && (r_a3[k] != 5'd0);
        end
    end

    // Scan oldest to youngest so the youngest match overwrites older (shadowed) ones.
    // Non-writers never match, which also keeps $0 out of every lookup.
    always_comb begin
        w_rs_hit   = 1'b0;
        w_rt_hit   = 1'b0;
        w_rs_tnew  = '0;
        w_rt_tnew  = '0;
        o_d_sel_rs = '0;
        o_d_sel_rt = '0;
        o_e_sel_a  = '0;
        o_e_sel_b  = '0;
        o_m_sel_rt = '0;
        for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
            if (w_writer[k] && (r_a3[k] == i_d_a1)) begin
                w_rs_hit   = 1'b1;
                w_rs_tnew  = r_tnew[k];
                o_d_sel_rs = (r_tnew[k] == '0) ? SEL_W'(k + 1) : '0;
            end
            if (w_writer[k] && (r_a3[k] == i_d_a2)) begin
                w_rt_hit   = 1'b1;
                w_rt_tnew  = r_tnew[k];
                o_d_sel_rt = (r_tnew[k] == '0) ? SEL_W'(k + 1) : '0;
            end
            if ((k >= 1) && w_writer[k] && (r_a3[k] == r_a1[0])) begin
                o_e_sel_a = (r_tnew[k] == '0) ? SEL_W'(k + 1) : '0;
            end
            if ((k >= 1) && w_writer[k] && (r_a3[k] == r_a2[0])) begin
                o_e_sel_b = (r_tnew[k] == '0) ? SEL_W'(k + 1) : '0;
            end
            if ((k >= 2) && w_writer[k] && (r_a3[k] == r_a2[1])) begin
                o_m_sel_rt = (r_tnew[k] == '0) ? SEL_W'(k + 1) : '0;
            end
        end
    end

    assign o_md_busy  = (r_md_cnt != '0);
    assign w_stall_rs = w_rs_hit && (w_rs_tnew > i_d_tuse_rs);
    assign w_stall_rt = w_rt_hit && (w_rt_tnew > i_d_tuse_rt);
    assign w_stall_md = i_d_md_use && o_md_busy;
    assign o_stall    = i_d_valid && (w_stall_rs || w_stall_rt || w_stall_md);
    assign w_issue    = i_d_valid && !o_stall && !i_flush;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                r_valid[k] <= 1'b0;
                r_a1[k]    <= '0;
                r_a2[k]    <= '0;
                r_a3[k]    <= '0;
                r_tnew[k]  <= '0;
            end
            r_md_cnt <= '0;
        end else begin
            for (int k = 1; k < int'(DEPTH); k++) begin
                r_valid[k] <= r_valid[k-1];
                r_a1[k]    <= r_a1[k-1];
                r_a2[k]    <= r_a2[k-1];
                r_a3[k]    <= r_a3[k-1];
                r_tnew[k]  <= (r_tnew[k-1] != '0) ? r_tnew[k-1] - TNEW_W'(1) : '0;
            end
            if (w_issue) begin
                r_valid[0] <= 1'b1;
                r_a1[0]    <= i_d_a1;
                r_a2[0]    <= i_d_a2;
                r_a3[0]    <= i_d_a3;
                r_tnew[0]  <= i_d_tnew;
            end else begin
                // Bubble: clear addresses too so an empty E never requests a forward
                r_valid[0] <= 1'b0;
                r_a1[0]    <= '0;
                r_a2[0]    <= '0;
                r_a3[0]    <= '0;
                r_tnew[0]  <= '0;
            end
            if (w_issue && i_d_md_start) begin
                r_md_cnt <= i_d_md_div ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
            end else if (r_md_cnt != '0) begin
                r_md_cnt <= r_md_cnt - CNT_W'(1);
            end
        end
    end

endmodule
